// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite HTRANS encodings and splitter decode-error FSM states
package ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  typedef enum logic [1:0] {DEC_IDLE, DEC_ERR1, DEC_ERR2} dec_state_t;
endpackage

// File: rtl/onehot_mux.sv
// onehot_mux: AND-OR selector of N W-bit inputs by a one-hot (or zero) select
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) dout = dout | (din[i*W +: W] & {W{sel[i]}});
  end
endmodule

// File: rtl/ahbl_splitter.sv
// ahbl_splitter: one AHB-Lite master to N_PORTS slaves with address decode and response mux.
// Define AHBL_SPLITTER_DECERR_EN to answer unmapped active transfers with a two-cycle ERROR.
module ahbl_splitter
  import ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP = {32'h40000000, 32'h00000000},
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf0000000, 32'hf0000000},
  parameter logic [N_PORTS-1:0] CONN_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W_ADDR-1:0]         src_haddr,
  input  logic                      src_hwrite,
  input  logic [1:0]                src_htrans,
  input  logic [2:0]                src_hsize,
  input  logic [2:0]                src_hburst,
  input  logic [3:0]                src_hprot,
  input  logic                      src_hmastlock,
  input  logic [W_DATA-1:0]         src_hwdata,
  input  logic                      src_hexcl,
  input  logic [7:0]                src_hmaster,
  input  logic [W_ADDR-1:0]         src_d_pc,
  input  logic [W_DATA-1:0]         src_hartid,
  input  logic                      src_hready,
  output logic                      src_hready_resp,
  output logic                      src_hresp,
  output logic                      src_hexokay,
  output logic [W_DATA-1:0]         src_hrdata,
  output logic [N_PORTS*W_ADDR-1:0] dst_haddr,
  output logic [N_PORTS-1:0]        dst_hwrite,
  output logic [N_PORTS*2-1:0]      dst_htrans,
  output logic [N_PORTS*3-1:0]      dst_hsize,
  output logic [N_PORTS*3-1:0]      dst_hburst,
  output logic [N_PORTS*4-1:0]      dst_hprot,
  output logic [N_PORTS-1:0]        dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0] dst_hwdata,
  output logic [N_PORTS-1:0]        dst_hexcl,
  output logic [N_PORTS*8-1:0]      dst_hmaster,
  output logic [N_PORTS*W_ADDR-1:0] dst_d_pc,
  output logic [N_PORTS*W_DATA-1:0] dst_hartid,
  output logic [N_PORTS-1:0]        dst_hready,
  input  logic [N_PORTS-1:0]        dst_hready_resp,
  input  logic [N_PORTS-1:0]        dst_hresp,
  input  logic [N_PORTS-1:0]        dst_hexokay,
  input  logic [N_PORTS*W_DATA-1:0] dst_hrdata,
  output logic [N_PORTS-1:0]        split_slave_sel_d
);
  logic [N_PORTS-1:0] match, slave_sel_a;
  logic mux_ready, mux_resp, mux_exokay, err_act, err_rdy;
  logic [W_DATA-1:0] mux_rdata;
  always_comb begin
    match = '0;
    for (int i = 0; i < N_PORTS; i++)
      match[i] = CONN_MASK[i] && ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]);
  end
  // isolate the lowest set bit so the lowest-index match wins
  assign slave_sel_a = match & (~match + N_PORTS'(1));
  for (genvar g = 0; g < N_PORTS; g++) begin : g_trans
    assign dst_htrans[g*2 +: 2] = slave_sel_a[g] ? src_htrans : HTRANS_IDLE;
  end
  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};
  assign dst_hexcl     = {N_PORTS{src_hexcl}};
  assign dst_hmaster   = {N_PORTS{src_hmaster}};
  assign dst_d_pc      = {N_PORTS{src_d_pc}};
  assign dst_hartid    = {N_PORTS{src_hartid}};
  assign dst_hready    = {N_PORTS{src_hready}};
  always_ff @(posedge clk)
    if (rst) split_slave_sel_d <= '0;
    else if (src_hready) split_slave_sel_d <= src_htrans[1] ? slave_sel_a : '0;
  onehot_mux #(.N(N_PORTS), .W(1)) u_mux_ready (.sel(split_slave_sel_d), .din(dst_hready_resp), .dout(mux_ready));
  onehot_mux #(.N(N_PORTS), .W(1)) u_mux_resp (.sel(split_slave_sel_d), .din(dst_hresp), .dout(mux_resp));
  onehot_mux #(.N(N_PORTS), .W(1)) u_mux_exokay (.sel(split_slave_sel_d), .din(dst_hexokay), .dout(mux_exokay));
  onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_mux_rdata (.sel(split_slave_sel_d), .din(dst_hrdata), .dout(mux_rdata));
`ifdef AHBL_SPLITTER_DECERR_EN
  dec_state_t state, state_nx;
  logic new_err;
  assign new_err = src_hready && src_htrans[1] && ~|slave_sel_a;
  assign state_nx = (state == DEC_ERR1) ? DEC_ERR2 : new_err ? DEC_ERR1 : DEC_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= DEC_IDLE;
      err_act <= 1'b0;
      err_rdy <= 1'b0;
    end else begin
      state <= state_nx;
      err_act <= state_nx != DEC_IDLE;
      err_rdy <= state_nx == DEC_ERR2;
    end
`else
  assign err_act = 1'b0;
  assign err_rdy = 1'b0;
`endif
  assign src_hready_resp = err_act ? err_rdy : (~|split_slave_sel_d | mux_ready);
  assign src_hresp = err_act | mux_resp;
  assign src_hexokay = ~err_act & mux_exokay;
  assign src_hrdata = err_act ? '0 : mux_rdata;
endmodule

// File: tb/tb_ahbl_splitter.sv
// tb_ahbl_splitter: directed checks of decode, broadcast, response mux, stalls, reset and decode errors
module tb_ahbl_splitter;
  logic clk = 0, rst;
  logic [31:0] src_haddr, src_hwdata, src_d_pc, src_hartid, src_hrdata;
  logic src_hwrite, src_hmastlock, src_hexcl, src_hready, src_hready_resp, src_hresp, src_hexokay;
  logic [1:0] src_htrans;
  logic [2:0] src_hsize, src_hburst;
  logic [3:0] src_hprot;
  logic [7:0] src_hmaster;
  logic [63:0] dst_haddr, dst_hwdata, dst_d_pc, dst_hartid, dst_hrdata;
  logic [1:0] dst_hwrite, dst_hmastlock, dst_hexcl, dst_hready, dst_hready_resp, dst_hresp, dst_hexokay, sel_d;
  logic [3:0] dst_htrans;
  logic [5:0] dst_hsize, dst_hburst;
  logic [7:0] dst_hprot;
  logic [15:0] dst_hmaster;
  logic [3:0] ov_htrans [2];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  ahbl_splitter dut (
    .clk(clk), .rst(rst), .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot), .src_hmastlock(src_hmastlock),
    .src_hwdata(src_hwdata), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_d_pc(src_d_pc),
    .src_hartid(src_hartid), .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_hexokay(src_hexokay), .src_hrdata(src_hrdata), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
    .dst_htrans(dst_htrans), .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster),
    .dst_d_pc(dst_d_pc), .dst_hartid(dst_hartid), .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp),
    .dst_hresp(dst_hresp), .dst_hexokay(dst_hexokay), .dst_hrdata(dst_hrdata), .split_slave_sel_d(sel_d)
  );

  // overlapping maps: k=0 has port 0 disconnected, k=1 has both connected
  for (genvar k = 0; k < 2; k++) begin : g_ov
    logic [63:0] haddr_o, hwdata_o, d_pc_o, hartid_o;
    logic [1:0] hwrite_o, mastlock_o, hexcl_o, hready_o, sel_o;
    logic [5:0] hsize_o, hburst_o;
    logic [7:0] hprot_o;
    logic [15:0] hmaster_o;
    logic rr, rs, rx;
    logic [31:0] rd;
    ahbl_splitter #(
      .ADDR_MAP({32'h40000000, 32'h40000000}),
      .CONN_MASK(k == 0 ? 2'b10 : 2'b11)
    ) u_ov (
      .clk(clk), .rst(rst), .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
      .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot), .src_hmastlock(src_hmastlock),
      .src_hwdata(src_hwdata), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_d_pc(src_d_pc),
      .src_hartid(src_hartid), .src_hready(src_hready), .src_hready_resp(rr), .src_hresp(rs),
      .src_hexokay(rx), .src_hrdata(rd), .dst_haddr(haddr_o), .dst_hwrite(hwrite_o),
      .dst_htrans(ov_htrans[k]), .dst_hsize(hsize_o), .dst_hburst(hburst_o), .dst_hprot(hprot_o),
      .dst_hmastlock(mastlock_o), .dst_hwdata(hwdata_o), .dst_hexcl(hexcl_o), .dst_hmaster(hmaster_o),
      .dst_d_pc(d_pc_o), .dst_hartid(hartid_o), .dst_hready(hready_o), .dst_hready_resp(dst_hready_resp),
      .dst_hresp(dst_hresp), .dst_hexokay(dst_hexokay), .dst_hrdata(dst_hrdata), .split_slave_sel_d(sel_o)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; src_hready = 1; src_htrans = 2'b00; src_haddr = '0; src_hwrite = 0;
    src_hsize = 3'b010; src_hburst = 3'b000; src_hprot = 4'b0011; src_hmastlock = 0;
    src_hwdata = '0; src_hexcl = 0; src_hmaster = 8'h5a; src_d_pc = 32'h1000; src_hartid = 32'h3;
    dst_hready_resp = 2'b11; dst_hresp = 2'b00; dst_hexokay = 2'b00;
    dst_hrdata = {32'hdeadbeef, 32'h11111111};
    repeat (2) step();
    mid();
    check("reset_sel", sel_d, 2'b00);
    check("reset_ready", src_hready_resp, 1'b1);
    check("reset_resp", src_hresp, 1'b0);
    rst = 0;
    // NSEQ read to port 1, zero waits
    step();
    src_haddr = 32'h40000010; src_htrans = 2'b10; dst_hexokay = 2'b10;
    mid();
    check("rd_htrans", dst_htrans, 4'b1000);
    check("rd_haddr_bcast", dst_haddr, {2{32'h40000010}});
    check("rd_hmaster_bcast", dst_hmaster, 16'h5a5a);
    check("rd_hready_bcast", dst_hready, 2'b11);
    step();
    src_htrans = 2'b00;
    mid();
    check("rd_sel", sel_d, 2'b10);
    check("rd_hrdata", src_hrdata, 32'hdeadbeef);
    check("rd_ready", src_hready_resp, 1'b1);
    check("rd_exokay", src_hexokay, 1'b1);
    check("rd_idle_htrans", dst_htrans, 4'b0000);
    step();
    mid();
    check("idle_sel", sel_d, 2'b00);
    check("idle_hrdata", src_hrdata, 32'h0);
    check("idle_exokay", src_hexokay, 1'b0);
    dst_hexokay = 2'b00;
    // write to port 0 with a 3-cycle stall
    step();
    src_haddr = 32'h00000004; src_hwrite = 1; src_htrans = 2'b10;
    mid();
    check("wr_htrans", dst_htrans, 4'b0010);
    step();
    src_htrans = 2'b00; src_hwrite = 0; src_hwdata = 32'h12345678;
    dst_hready_resp = 2'b10; dst_hresp = 2'b01; src_hready = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("stall_ready", src_hready_resp, 1'b0);
      check("stall_sel", sel_d, 2'b01);
      check("stall_resp", src_hresp, 1'b1);
      step();
    end
    dst_hready_resp = 2'b11; dst_hresp = 2'b00; src_hready = 1;
    mid();
    check("wr_done_ready", src_hready_resp, 1'b1);
    check("wr_done_resp", src_hresp, 1'b0);
    check("wr_done_sel", sel_d, 2'b01);
    check("wr_hwdata_bcast", dst_hwdata, {2{32'h12345678}});
    // unmapped NSEQ
    step();
    src_haddr = 32'h80000000; src_htrans = 2'b10;
    mid();
    check("unmap_htrans", dst_htrans, 4'b0000);
    step();
`ifdef AHBL_SPLITTER_DECERR_EN
    src_hready = 0;
    mid();
    check("err1_ready", src_hready_resp, 1'b0);
    check("err1_resp", src_hresp, 1'b1);
    check("err1_hrdata", src_hrdata, 32'h0);
    check("err1_htrans", dst_htrans, 4'b0000);
    step();
    src_hready = 1;
    mid();
    check("err2_ready", src_hready_resp, 1'b1);
    check("err2_resp", src_hresp, 1'b1);
    step();
    src_hready = 0;
    mid();
    check("b2b_err1_ready", src_hready_resp, 1'b0);
    check("b2b_err1_resp", src_hresp, 1'b1);
    step();
    src_hready = 1; src_htrans = 2'b00;
    mid();
    check("b2b_err2_ready", src_hready_resp, 1'b1);
    check("b2b_err2_resp", src_hresp, 1'b1);
    step();
    mid();
    check("err_done_ready", src_hready_resp, 1'b1);
    check("err_done_resp", src_hresp, 1'b0);
`else
    mid();
    check("unmap_ready", src_hready_resp, 1'b1);
    check("unmap_resp", src_hresp, 1'b0);
    check("unmap_hrdata", src_hrdata, 32'h0);
    check("unmap_sel", sel_d, 2'b00);
    step();
    src_htrans = 2'b00;
    mid();
    check("unmap2_ready", src_hready_resp, 1'b1);
    check("unmap2_resp", src_hresp, 1'b0);
`endif
    // reset in ERR1 (decode-error build only)
`ifdef AHBL_SPLITTER_DECERR_EN
    step();
    src_haddr = 32'h80000000; src_htrans = 2'b10;
    step();
    src_htrans = 2'b00;
    mid();
    check("rst_err1_pre", src_hready_resp, 1'b0);
    rst = 1;
    step();
    rst = 0;
    mid();
    check("rst_err1_sel", sel_d, 2'b00);
    check("rst_err1_ready", src_hready_resp, 1'b1);
    check("rst_err1_resp", src_hresp, 1'b0);
`endif
    // reset during a stalled port-1 data phase
    step();
    src_haddr = 32'h40000000; src_htrans = 2'b10;
    step();
    src_htrans = 2'b00; src_hready = 0; dst_hready_resp = 2'b01; dst_hresp = 2'b10;
    mid();
    check("rst_stall_pre_ready", src_hready_resp, 1'b0);
    check("rst_stall_pre_sel", sel_d, 2'b10);
    rst = 1;
    step();
    rst = 0; src_hready = 1;
    mid();
    check("rst_stall_sel", sel_d, 2'b00);
    check("rst_stall_ready", src_hready_resp, 1'b1);
    check("rst_stall_resp", src_hresp, 1'b0);
    dst_hready_resp = 2'b11; dst_hresp = 2'b00;
    // overlapping address map priority
    step();
    src_haddr = 32'h40000000; src_htrans = 2'b10;
    mid();
    check("ov_conn10", ov_htrans[0], 4'b1000);
    check("ov_conn11", ov_htrans[1], 4'b0010);
    step();
    src_htrans = 2'b00;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
